// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions.
//   tap_state_e  : the 16 TAP states with the legacy 4-bit encodings
//   IrCapture    : fixed pattern loaded into the IR LSBs in Capture-IR
//   is_bypass_op : true when the low `len` bits of an opcode are all ones
package jtag_pkg;

  typedef enum logic [3:0] {
    StEx2Dr = 4'h0,
    StEx1Dr = 4'h1,
    StShDr  = 4'h2,
    StPauDr = 4'h3,
    StSelIr = 4'h4,
    StUpdDr = 4'h5,
    StCapDr = 4'h6,
    StSelDr = 4'h7,
    StEx2Ir = 4'h8,
    StEx1Ir = 4'h9,
    StShIr  = 4'hA,
    StPauIr = 4'hB,
    StRti   = 4'hC,
    StUpdIr = 4'hD,
    StCapIr = 4'hE,
    StTlr   = 4'hF
  } tap_state_e;

  localparam logic [1:0] IrCapture = 2'b01;

  function automatic logic is_bypass_op(input logic [31:0] op, input int unsigned len);
    logic [31:0] mask;
    mask = (len >= 32) ? '1 : ((32'd1 << len) - 32'd1);
    return (op & mask) == mask;
  endfunction

endpackage

// File: rtl/jtag_tap_core_if.sv
// Pin-side and chain-side signals of the TAP core.
//   master : the TAP core (consumes TMS/TDI/USER_TDO, drives TDO and chain controls)
//   slave  : the pins / user chains on the other side
interface jtag_tap_core_if #(
  parameter int unsigned IR_LEN   = 4,
  parameter int unsigned NUM_USER = 2
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic                TAP_rst;
  logic [IR_LEN-1:0]   INSTR;
  logic                CAPTUREDR;
  logic                SHIFTDR;
  logic                UPDATEDR;
  logic [NUM_USER-1:0] USER_SEL;
  logic [NUM_USER-1:0] USER_TDO;

  modport master (
    input  TMS, TDI, USER_TDO,
    output TDO, TDO_EN, TAP_rst, INSTR, CAPTUREDR, SHIFTDR, UPDATEDR, USER_SEL
  );

  modport slave (
    output TMS, TDI, USER_TDO,
    input  TDO, TDO_EN, TAP_rst, INSTR, CAPTUREDR, SHIFTDR, UPDATEDR, USER_SEL
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller.
//   TCK, TRST (async active-low), TMS : inputs
//   state_o   : current state register
//   state_d_o : next state (valid before the coming posedge TCK)
//   TAP_rst, CAPTUREDR, SHIFTDR, UPDATEDR : decoded straight from the state register
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state_o,
  output tap_state_e state_d_o,
  output logic       TAP_rst,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = StTlr;
    unique case (state_q)
      StTlr:   state_d = TMS ? StTlr   : StRti;
      StRti:   state_d = TMS ? StSelDr : StRti;
      StSelDr: state_d = TMS ? StSelIr : StCapDr;
      StCapDr: state_d = TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS ? StUpdDr : StPauDr;
      StPauDr: state_d = TMS ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS ? StSelDr : StRti;
      StSelIr: state_d = TMS ? StTlr   : StCapIr;
      StCapIr: state_d = TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS ? StUpdIr : StPauIr;
      StPauIr: state_d = TMS ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // Single-register decodes: no combinational path from TMS, so no glitches.
  assign TAP_rst   = (state_q == StTlr);
  assign CAPTUREDR = (state_q == StCapDr);
  assign SHIFTDR   = (state_q == StShDr);
  assign UPDATEDR  = (state_q == StUpdDr);

  assign state_o   = state_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: TAP FSM, instruction register, BYPASS and optional IDCODE data
// registers, one-hot user-chain decode and a falling-edge TDO mux.
//   TCK     : test clock (sole clock)
//   TRST    : asynchronous active-low reset
//   jtag_io : master modport of jtag_tap_core_if (TMS/TDI/TDO/TDO_EN, TAP_rst,
//             INSTR, CAPTUREDR/SHIFTDR/UPDATEDR, USER_SEL, USER_TDO)
// Build option: define JTAG_TAP_IDCODE_EN to build the 32-bit IDCODE register and
// make IDCODE_OP the reset instruction; otherwise the reset instruction is BYPASS.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned       IR_LEN       = 4,
  parameter int unsigned       NUM_USER     = 2,
  parameter logic [IR_LEN-1:0] USER_BASE    = 'h8,
  parameter logic [IR_LEN-1:0] IDCODE_OP    = 'h1,
  parameter logic [31:0]       IDCODE_VALUE = 32'h1000_0001
) (
  input logic             TCK,
  input logic             TRST,
  jtag_tap_core_if.master jtag_io
);

  if (IR_LEN < 2) begin : g_chk_ir_len
    $error("IR_LEN must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_chk_idcode
    $error("IDCODE_VALUE bit 0 must be 1");
  end
  if (IDCODE_OP == '1) begin : g_chk_idcode_op
    $error("IDCODE_OP must not be the BYPASS opcode");
  end

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] InstrRst = IDCODE_OP;
`else
  localparam logic [IR_LEN-1:0] InstrRst = '1;
`endif

  tap_state_e state_q, state_d;
  logic       tap_rst, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (jtag_io.TMS),
    .state_o   (state_q),
    .state_d_o (state_d),
    .TAP_rst   (tap_rst),
    .CAPTUREDR (capture_dr),
    .SHIFTDR   (shift_dr),
    .UPDATEDR  (update_dr)
  );

  logic capture_ir, shift_ir, update_ir;
  assign capture_ir = (state_q == StCapIr);
  assign shift_ir   = (state_q == StShIr);
  assign update_ir  = (state_q == StUpdIr);

  // Instruction register
  logic [IR_LEN-1:0] ir_sr_q, instr_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q <= '0;
      instr_q <= InstrRst;
    end else begin
      if (capture_ir) begin
        ir_sr_q <= IR_LEN'(IrCapture);
      end else if (shift_ir) begin
        ir_sr_q <= {jtag_io.TDI, ir_sr_q[IR_LEN-1:1]};
      end
      // Reload on the edge that enters TLR; Update-IR never leads to TLR directly.
      if (state_d == StTlr) begin
        instr_q <= InstrRst;
      end else if (update_ir) begin
        instr_q <= ir_sr_q;
      end
    end
  end

  // Instruction decode, registered one TCK behind INSTR
  logic                instr_bypass;
  logic [NUM_USER-1:0] user_sel_d, user_sel_q;

  assign instr_bypass = is_bypass_op(32'(instr_q), IR_LEN);

`ifdef JTAG_TAP_IDCODE_EN
  logic idcode_sel_d, idcode_sel_q;
`endif

  always_comb begin
    user_sel_d = '0;
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (!instr_bypass && (instr_q == IR_LEN'(32'(USER_BASE) + k))) begin
        user_sel_d[k] = 1'b1;
      end
    end
`ifdef JTAG_TAP_IDCODE_EN
    idcode_sel_d = !instr_bypass && (instr_q == IDCODE_OP);
    if (idcode_sel_d) begin
      user_sel_d = '0;
    end
`endif
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      user_sel_q <= '0;
    end else begin
      user_sel_q <= user_sel_d;
    end
  end

  // BYPASS register
  logic bypass_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_q <= 1'b0;
    end else if (capture_dr) begin
      bypass_q <= 1'b0;
    end else if (shift_dr) begin
      bypass_q <= jtag_io.TDI;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  // IDCODE register
  logic [31:0] idcode_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      idcode_q     <= IDCODE_VALUE;
      idcode_sel_q <= 1'b1;
    end else begin
      idcode_sel_q <= idcode_sel_d;
      if (capture_dr) begin
        idcode_q <= IDCODE_VALUE;
      end else if (shift_dr) begin
        idcode_q <= {jtag_io.TDI, idcode_q[31:1]};
      end
    end
  end
`endif

  // Data-register output select; unmatched opcodes fall through to BYPASS.
  logic dr_tdo;

  always_comb begin
    dr_tdo = bypass_q;
`ifdef JTAG_TAP_IDCODE_EN
    if (idcode_sel_q) begin
      dr_tdo = idcode_q[0];
    end
`endif
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (user_sel_q[k]) begin
        dr_tdo = jtag_io.USER_TDO[k];
      end
    end
  end

  // TDO retimed to the falling edge so it is stable around the next rising edge.
  logic tdo_d, tdo_en_d, tdo_q, tdo_en_q;

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (shift_ir) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (shift_dr) begin
      tdo_d    = dr_tdo;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign jtag_io.TDO       = tdo_q;
  assign jtag_io.TDO_EN    = tdo_en_q;
  assign jtag_io.TAP_rst   = tap_rst;
  assign jtag_io.INSTR     = instr_q;
  assign jtag_io.CAPTUREDR = capture_dr;
  assign jtag_io.SHIFTDR   = shift_dr;
  assign jtag_io.UPDATEDR  = update_dr;
  assign jtag_io.USER_SEL  = user_sel_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core. Expected TDO bits are queued as each scan
// is set up and popped as the DUT presents them. Honours JTAG_TAP_IDCODE_EN.
module tb_jtag_tap_core;
  import jtag_pkg::*;

  localparam int unsigned IrLen       = 4;
  localparam int unsigned NumUser     = 2;
  localparam logic [31:0] IdcodeValue = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] InstrRst = 4'h1;
`else
  localparam logic [3:0] InstrRst = 4'hF;
`endif

  logic TCK  = 1'b0;
  logic TRST = 1'b1;

  jtag_tap_core_if #(.IR_LEN(IrLen), .NUM_USER(NumUser)) jtag ();

  jtag_tap_core #(
    .IR_LEN       (IrLen),
    .NUM_USER     (NumUser),
    .USER_BASE    (4'h8),
    .IDCODE_OP    (4'h1),
    .IDCODE_VALUE (IdcodeValue)
  ) dut (
    .TCK     (TCK),
    .TRST    (TRST),
    .jtag_io (jtag)
  );

  always #5 TCK = ~TCK;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  logic [3:0] walk_code [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                 4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
  int         walk_len  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  // TMS sequences from TLR, applied LSB first
  logic [7:0] walk_seq  [16] = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010,
                                 8'b101010, 8'b11010, 8'b110, 8'b0110, 8'b00110, 8'b10110,
                                 8'b010110, 8'b1010110, 8'b110110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns after the next one.
  task automatic tick(input logic tms, input logic tdi);
    jtag.TMS = tms;
    jtag.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic sample(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(jtag.TDO), 32'(e));
      check({tag, "_en"}, 32'(jtag.TDO_EN), 32'd1);
    end
  endtask

  // RTI -> IR scan of val -> RTI; the captured IR pattern is queued as expected TDO.
  task automatic ir_scan(input logic [3:0] val);
    for (int i = 0; i < int'(IrLen); i++) exp_q.push_back(i == 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < int'(IrLen); i++) begin
      sample("ir_tdo");
      tick(i == int'(IrLen) - 1, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // RTI -> DR scan of n bits -> RTI; caller queues the expected TDO bits.
  task automatic dr_scan(input int n, input logic [63:0] tdi);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      sample("dr_tdo");
      tick(i == n - 1, tdi[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] pat;
    logic [4:0] utdo;

    jtag.TMS = 1'b1;
    jtag.TDI = 1'b0;
    jtag.USER_TDO = '0;

    // Reset state
    #1 TRST = 1'b0;
    #11;
    check("rst_state", 32'(dut.state_q), 32'hF);
    check("rst_taprst", 32'(jtag.TAP_rst), 32'd1);
    check("rst_instr", 32'(jtag.INSTR), 32'(InstrRst));
    check("rst_tdo", 32'({jtag.TDO, jtag.TDO_EN}), 32'd0);
    check("rst_strobes", 32'({jtag.CAPTUREDR, jtag.SHIFTDR, jtag.UPDATEDR}), 32'd0);
    check("rst_usersel", 32'(jtag.USER_SEL), 32'd0);
    TRST = 1'b1;

    // Every state reaches TLR with five TMS=1 cycles
    for (int s = 0; s < 16; s++) begin
      repeat (5) tick(1'b1, 1'b0);
      for (int b = 0; b < walk_len[s]; b++) tick(walk_seq[s][b], 1'b0);
      check($sformatf("walk_state_%0h", walk_code[s]), 32'(dut.state_q), 32'(walk_code[s]));
      check($sformatf("walk_strobe_%0h", walk_code[s]),
            32'({jtag.TAP_rst, jtag.CAPTUREDR, jtag.SHIFTDR, jtag.UPDATEDR}),
            32'({walk_code[s] == 4'hF, walk_code[s] == 4'h6, walk_code[s] == 4'h2,
                 walk_code[s] == 4'h5}));
      repeat (5) tick(1'b1, 1'b0);
      check($sformatf("walk_tlr_%0h", walk_code[s]), 32'(dut.state_q), 32'hF);
      check($sformatf("walk_taprst_%0h", walk_code[s]), 32'(jtag.TAP_rst), 32'd1);
    end

    // DR scan straight after reset: IDCODE, or BYPASS when compiled out
    #2 TRST = 1'b0;
    #2 TRST = 1'b1;
    tick(1'b0, 1'b0);
    check("post_rst_instr", 32'(jtag.INSTR), 32'(InstrRst));
    for (int i = 0; i < 32; i++) begin
`ifdef JTAG_TAP_IDCODE_EN
      exp_q.push_back(IdcodeValue[i]);
`else
      exp_q.push_back(1'b0);
`endif
    end
    dr_scan(32, 64'd0);

    // BYPASS: IR=F, TDI 1,0,1,1,0 comes back one TCK later behind the captured 0
    ir_scan(4'hF);
    check("bypass_instr", 32'(jtag.INSTR), 32'hF);
    tick(1'b0, 1'b0);
    check("bypass_usersel", 32'(jtag.USER_SEL), 32'd0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    dr_scan(5, 64'b01101);

    // User chain 1: select lags INSTR by one TCK, TDO follows USER_TDO[1]
    ir_scan(4'h9);
    check("user1_instr", 32'(jtag.INSTR), 32'h9);
    check("user1_sel_lag", 32'(jtag.USER_SEL), 32'b00);
    check("user1_en_rti", 32'(jtag.TDO_EN), 32'd0);
    tick(1'b0, 1'b0);
    check("user1_sel", 32'(jtag.USER_SEL), 32'b10);
    utdo = 5'b01011;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("user1_capdr", 32'(jtag.CAPTUREDR), 32'd1);
    for (int i = 0; i < 5; i++) begin
      jtag.USER_TDO = {utdo[i], ~utdo[i]};
      exp_q.push_back(utdo[i]);
      tick(1'b0, 1'b0);
      sample("user1_tdo");
    end
    tick(1'b1, 1'b0);
    check("user1_ex1_tdo", 32'({jtag.TDO, jtag.TDO_EN}), 32'd0);
    tick(1'b1, 1'b0);
    check("user1_upddr", 32'(jtag.UPDATEDR), 32'd1);
    tick(1'b0, 1'b0);
    jtag.USER_TDO = '0;

    // User chain 0
    ir_scan(4'h8);
    tick(1'b0, 1'b0);
    check("user0_sel", 32'(jtag.USER_SEL), 32'b01);

    // TRST mid Shift-IR after two bits: immediate reset, partial IR discarded
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("trst_pre_en", 32'(jtag.TDO_EN), 32'd1);
    #1 TRST = 1'b0;
    #1;
    check("trst_state", 32'(dut.state_q), 32'hF);
    check("trst_instr", 32'(jtag.INSTR), 32'(InstrRst));
    check("trst_tdo_en", 32'(jtag.TDO_EN), 32'd0);
    check("trst_taprst", 32'(jtag.TAP_rst), 32'd1);
    @(posedge TCK);
    #2;
    check("trst_dominates", 32'(dut.state_q), 32'hF);
    TRST = 1'b1;
    @(negedge TCK);
    #1;
    tick(1'b0, 1'b0);
    check("trst_rel_state", 32'(dut.state_q), 32'hC);
    check("trst_rel_instr", 32'(jtag.INSTR), 32'(InstrRst));

    // IDCODE_OP scan with a pause in the middle: bits resume from bit 3
    ir_scan(4'h1);
    check("pause_instr", 32'(jtag.INSTR), 32'h1);
    tick(1'b0, 1'b0);
    pat = 10'($urandom_range(0, 1023));
    pat[2] = 1'b0;
    for (int j = 0; j < 10; j++) begin
`ifdef JTAG_TAP_IDCODE_EN
      exp_q.push_back(IdcodeValue[j]);
`else
      exp_q.push_back((j == 0) ? 1'b0 : pat[j-1]);
`endif
    end
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    sample("pause_tdo");
    tick(1'b0, pat[0]);
    sample("pause_tdo");
    tick(1'b0, pat[1]);
    sample("pause_tdo");
    tick(1'b1, pat[2]);
    check("pause_ex1", 32'({4'(dut.state_q), jtag.TDO_EN}), 32'({4'h1, 1'b0}));
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("pause_pau", 32'({4'(dut.state_q), jtag.TDO_EN}), 32'({4'h3, 1'b0}));
    tick(1'b1, 1'b1);
    check("pause_ex2", 32'(dut.state_q), 32'h0);
    tick(1'b0, 1'b1);
    for (int j = 3; j < 10; j++) begin
      sample("pause_tdo");
      tick(j == 9, pat[j]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("pause_rti_en", 32'(jtag.TDO_EN), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
Name: jtag_tap_core

Overview:
Full IEEE 1149.1 TAP: 16-state controller, parametrised instruction register, built-in BYPASS and IDCODE registers, and a TDO mux over N user data registers. It is the next generation of the team's TAP controller. Additions over that controller:
- Exit2→Shift resume transitions.
- Capture strobes.
- Falling-edge TDO with output enable.
- Instruction decode into one-hot user-chain selects.

It sits between the device JTAG pins and the user scan chains.

Parameters:
IR_LEN, 4, instruction register width (≥2)
NUM_USER, 2, number of user data registers (≥1)
USER_BASE, 4'h8, opcode of user chain 0; chain k uses USER_BASE+k
IDCODE_OP, 4'h1, IDCODE opcode
IDCODE_VALUE, 32'h1000_0001, IDCODE contents; bit 0 must be 1

Ports:
TCK  input  1  test clock; sole clock
TRST  input  1  async active-low reset
TMS  input  1  mode select, sampled posedge TCK
TDI  input  1  serial in, sampled posedge TCK
TDO  output  1  serial out, changes on negedge TCK
TDO_EN  output  1  TDO driver enable
TAP_rst  output  1  high while in Test-Logic-Reset
INSTR  output  IR_LEN  current instruction
CAPTUREDR  output  1  high in Capture-DR
SHIFTDR  output  1  high in Shift-DR
UPDATEDR  output  1  high in Update-DR
USER_SEL  output  NUM_USER  one-hot user-chain select
USER_TDO  input  NUM_USER  serial out of each user chain

Behaviour:
- Reset: TRST low asynchronously forces the following:
  - state = Test-Logic-Reset (4'hF);
  - INSTR = IDCODE_OP, or all-ones when IDCODE is compiled out;
  - IR shift register = 0;
  - TDO = 0, TDO_EN = 0;
  - TAP_rst = 1, all strobes 0, USER_SEL = 0.
- State encoding: reuse the team's 4-bit codes (TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D).
- FSM: standard 1149.1 transitions on posedge TCK. Ex2DR/Ex2IR go to Update on TMS=1 and back to Shift on TMS=0. Five consecutive TMS=1 cycles reach TLR from any state. Unused codes are not reachable.
- Strobes: TAP_rst, CAPTUREDR, SHIFTDR and UPDATEDR are decoded combinationally from the state register (glitch-free). Each is high for exactly the cycles spent in its state.
- IR path:
  - Capture-IR loads {0…0,1} (LSBs = 2'b01).
  - Shift-IR shifts right: TDI enters the MSB, the LSB goes to TDO.
  - On the posedge leaving Update-IR, INSTR ← IR shift register.
  - Entering TLR reloads INSTR with its reset value.
- Decode:
  - Opcode = all-ones → BYPASS.
  - Opcode = IDCODE_OP → IDCODE.
  - Opcode = USER_BASE+k for k < NUM_USER → USER_SEL[k] = 1.
  - Any other opcode behaves as BYPASS.
  - USER_SEL is registered from INSTR and updates the cycle after INSTR changes.
- BYPASS: 1-bit register. Cleared in Capture-DR; loads TDI in Shift-DR. Gives a 1-cycle TDI→TDO delay.
- IDCODE: 32-bit register. Loads IDCODE_VALUE in Capture-DR; shifts right in Shift-DR with TDI entering bit 31.
- TDO mux selects, in priority order:
  - IR LSB in Shift-IR;
  - otherwise the selected DR LSB / USER_TDO[k] in Shift-DR.
- TDO and TDO_EN are registered on negedge TCK. TDO_EN = 1 only while in Shift-IR or Shift-DR; otherwise TDO = 0.
- Pause states hold every shift register. Update-DR has no internal effect; user chains use UPDATEDR.
- Simultaneous events:
  - TRST dominates TCK.
  - TRST released mid-scan: the scan restarts from TLR and the partial IR shift is discarded without updating INSTR.

Optional Feature:
JTAG_TAP_IDCODE_EN.
- Defined: the 32-bit IDCODE register exists and the reset instruction is IDCODE_OP. After reset, a DR scan returns IDCODE_VALUE LSB-first.
- Undefined: no IDCODE register is built. The reset instruction is all-ones (BYPASS), and IDCODE_OP decodes as BYPASS.

Decomposition:
- Package jtag_pkg holds:
  - the 16 state localparams;
  - a state typedef (4-bit);
  - BYPASS opcode helper;
  - a capture pattern constant.
- Sub-module jtag_tap_fsm (TCK, TRST, TMS → state, TAP_rst, strobe decode) is shared with the existing controller's replacement.
- Register and mux logic stays in jtag_tap_core.

Test Plan:
- From each of the 16 states apply TMS=1 ×5 → state 4'hF and TAP_rst=1 at every start state.
- Reset, then DR scan of 32 bits with TDI=0 → TDO yields 0x1000_0001 LSB-first (IDCODE_EN defined). Same scan with the macro undefined → bit0 = 0 (bypass).
- IR scan of IR_LEN=4 bits shifting in 4'hF → captured TDO bits 1,0,0,0. After Update-IR, INSTR=4'hF. A DR scan of pattern 1011 returns it delayed by one TCK.
- Load INSTR=4'h9 → USER_SEL=2'b10 one cycle later. TDO follows USER_TDO[1] during Shift-DR, and TDO_EN=0 outside shift states.
- DR scan: Shift ×3 → Exit1 → Pause ×2 → Exit2 → TMS=0 back to Shift → IDCODE bits continue from bit 3 with no bit lost or repeated.
- Assert TRST low mid Shift-IR after 2 bits → state F, INSTR=IDCODE_OP and TDO_EN=0 immediately, without waiting for a TCK edge.
